// File: rtl/tty_port_arb_if.sv
// Requester and character-port signals of tty_port_arb, grouped as one bundle.
// The arbiter uses the slave modport; requesters and the pin side use master.
interface tty_port_arb_if;
    logic       c0_req;
    logic [7:0] c0_dat;
    logic       c0_ack;
    logic       c1_req;
    logic [7:0] c1_dat;
    logic       c1_stop;
    logic       c1_ack;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       busy;

    modport slave (
        input  c0_req, c0_dat, c1_req, c1_dat, c1_stop,
        output c0_ack, c1_ack, lcd_data, lcd_en, lcd_rs, lcd_rw, busy
    );
    modport master (
        output c0_req, c0_dat, c1_req, c1_dat, c1_stop,
        input  c0_ack, c1_ack, lcd_data, lcd_en, lcd_rs, lcd_rw, busy
    );
endinterface

// File: rtl/tty_port_arb.sv
// Two-channel round-robin arbiter and setup/strobe/hold/gap sequencer for the
// DE0 character port. CONFIG_TTY_ARB_FIFO_EN adds a 4-entry channel 0 FIFO.
module tty_port_arb #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 8,
    parameter int T_HOLD  = 4,
    parameter int T_GAP   = 8
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n,
    tty_port_arb_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [7:0] L_SETUP = 8'(T_SETUP);
    localparam logic [7:0] L_EN    = 8'(T_EN);
    localparam logic [7:0] L_HOLD  = 8'(T_HOLD);
    localparam logic [7:0] L_GAP   = 8'(T_GAP);

    if (T_SETUP == 0 || T_EN == 0 || T_HOLD == 0) begin : g_bad_param
        $error("tty_port_arb: T_SETUP, T_EN and T_HOLD must be non-zero");
    end

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_data;
    logic       r_stop;
    logic       r_last;   // channel of the current/most recent grant

    logic       w_req0;
    logic [7:0] w_dat0;
    logic       w_grant1;
    logic       w_expire;
    logic       w_done;

    assign w_expire = (r_cnt == 8'd1);
    assign w_done   = (r_state == S_HOLD) && w_expire;
    assign w_grant1 = bus.c1_req && (!w_req0 || !r_last);

`ifdef CONFIG_TTY_ARB_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_fcnt;
    logic       r_c0_ack;
    logic       w_push;
    logic       w_pop;

    // The ack cycle still carries the acknowledged request, so it never pushes.
    assign w_pop  = w_done && !r_last;
    assign w_push = bus.c0_req && !r_c0_ack && ((r_fcnt != 3'd4) || w_pop);
    assign w_req0 = (r_fcnt != 3'd0);
    assign w_dat0 = r_fifo[r_rp];
    assign bus.c0_ack = r_c0_ack;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_fifo[r_wp] <= bus.c0_dat;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wp     <= 2'd0;
            r_rp     <= 2'd0;
            r_fcnt   <= 3'd0;
            r_c0_ack <= 1'b0;
        end else begin
            r_c0_ack <= w_push;
            if (w_push) r_wp <= r_wp + 2'd1;
            if (w_pop)  r_rp <= r_rp + 2'd1;
            r_fcnt <= r_fcnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end
`else
    assign w_req0 = bus.c0_req;
    assign w_dat0 = bus.c0_dat;
    assign bus.c0_ack = w_done && !r_last;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_data  <= 8'h00;
            r_stop  <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || bus.c1_req) begin
                        r_data  <= w_grant1 ? bus.c1_dat : w_dat0;
                        r_stop  <= w_grant1 && bus.c1_stop;
                        r_last  <= w_grant1;
                        r_cnt   <= L_SETUP;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_expire) begin
                        r_cnt   <= L_EN;
                        r_state <= S_STROBE;
                    end else r_cnt <= r_cnt - 8'd1;
                end
                S_STROBE: begin
                    if (w_expire) begin
                        r_cnt   <= L_HOLD;
                        r_state <= S_HOLD;
                    end else r_cnt <= r_cnt - 8'd1;
                end
                S_HOLD: begin
                    if (w_expire) begin
                        r_cnt   <= L_GAP;
                        r_state <= (T_GAP == 0) ? S_IDLE : S_GAP;
                    end else r_cnt <= r_cnt - 8'd1;
                end
                S_GAP: begin
                    if (w_expire) r_state <= S_IDLE;
                    else          r_cnt   <= r_cnt - 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode the registered state so reset removes them asynchronously.
    assign bus.lcd_data = r_data;
    assign bus.lcd_en   = (r_state == S_STROBE);
    assign bus.lcd_rs   = (r_state == S_STROBE) && r_stop;
    assign bus.lcd_rw   = 1'b0;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.c1_ack   = w_done && r_last;
endmodule

// File: tb/tb_tty_port_arb.sv
// Scoreboard bench for tty_port_arb: expected strobes are queued by the
// stimulus and checked by an independent monitor on every lcd_en pulse and ack.
module tb_tty_port_arb;
`ifdef CONFIG_TTY_ARB_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    localparam int T_EN = 8;

    typedef struct {
        int         ch;
        logic       rs;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tty_port_arb_if bus();

    tty_port_arb dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   ack_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: lcd_en rise pops the scoreboard, fall checks pulse and rs width.
    initial begin : monitor
        logic prev_en;
        int   en_cnt;
        int   rs_cnt;
        exp_t cur;
        prev_en = 1'b0;
        en_cnt  = 0;
        rs_cnt  = 0;
        cur     = '{ch: 0, rs: 1'b0, d: 8'h00};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
                en_cnt  = 0;
                rs_cnt  = 0;
                ack_q.delete();
            end else begin
                if (bus.lcd_en && !prev_en) begin
                    en_cnt = 0;
                    rs_cnt = 0;
                    if (sb.size() == 0) flag("unexpected_strobe");
                    else begin
                        cur = sb.pop_front();
                        chk("strobe_data", 32'(bus.lcd_data), 32'(cur.d));
                        chk("strobe_rs", 32'(bus.lcd_rs), 32'(cur.rs));
                        if (!(FIFO && cur.ch == 0)) ack_q.push_back(cur.ch);
                    end
                end
                if (bus.lcd_en) begin
                    en_cnt++;
                    if (bus.lcd_rs) rs_cnt++;
                end
                if (!bus.lcd_en && prev_en) begin
                    chk("en_width", 32'(en_cnt), 32'(T_EN));
                    chk("rs_width", 32'(rs_cnt), cur.rs ? 32'(T_EN) : 32'd0);
                end
                if (bus.c1_ack || (!FIFO && bus.c0_ack)) begin
                    if (ack_q.size() == 0) flag("unexpected_ack");
                    else chk("ack_chan", bus.c1_ack ? 32'd1 : 32'd0, 32'(ack_q.pop_front()));
                end
                prev_en = bus.lcd_en;
            end
        end
    end

    task automatic req_ch(input int ch, input logic [7:0] d, input logic stop);
        bit got;
        got = 1'b0;
        if (ch == 0) begin
            bus.c0_dat = d;
            bus.c0_req = 1'b1;
        end else begin
            bus.c1_dat  = d;
            bus.c1_stop = stop;
            bus.c1_req  = 1'b1;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (ch == 0) ? bus.c0_ack : bus.c1_ack;
        end
        if (!got) flag($sformatf("ack_timeout_ch%0d", ch));
        @(posedge clk);
        #1;
        if (ch == 0) bus.c0_req = 1'b0;
        else begin
            bus.c1_req  = 1'b0;
            bus.c1_stop = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && (bus.busy || sb.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        chk(name, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic en_a   [0:26];
        logic ack_a  [0:26];
        logic busy_a [0:26];
        bit   drop;
        int   w;
        bit   got;

        bus.c0_req = 1'b0; bus.c0_dat = 8'h00;
        bus.c1_req = 1'b0; bus.c1_dat = 8'h00; bus.c1_stop = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(bus.lcd_data), 32'h00);
        chk("rst_en",   {31'd0, bus.lcd_en}, 32'd0);
        chk("rst_rs",   {31'd0, bus.lcd_rs}, 32'd0);
        chk("rst_rw",   {31'd0, bus.lcd_rw}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_acks", {30'd0, bus.c0_ack, bus.c1_ack}, 32'd0);
        rst_n = 1'b1;

        // Single console byte, cycle-accurate latency
        @(posedge clk); #1;
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h41});
        bus.c0_dat = 8'h41;
        bus.c0_req = 1'b1;
        drop = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            if (drop) bus.c0_req = 1'b0;
            @(negedge clk);
            en_a[k]   = bus.lcd_en;
            ack_a[k]  = bus.c0_ack;
            busy_a[k] = bus.busy;
            if (bus.c0_ack) drop = 1'b1;
        end
        bus.c0_req = 1'b0;
        if (!FIFO) begin
            chk("lat_en_c4",    {31'd0, en_a[4]},    32'd0);
            chk("lat_en_c5",    {31'd0, en_a[5]},    32'd1);
            chk("lat_en_c12",   {31'd0, en_a[12]},   32'd1);
            chk("lat_en_c13",   {31'd0, en_a[13]},   32'd0);
            chk("lat_ack_c15",  {31'd0, ack_a[15]},  32'd0);
            chk("lat_ack_c16",  {31'd0, ack_a[16]},  32'd1);
            chk("lat_ack_c17",  {31'd0, ack_a[17]},  32'd0);
            chk("lat_busy_c24", {31'd0, busy_a[24]}, 32'd1);
            chk("lat_busy_c25", {31'd0, busy_a[25]}, 32'd0);
        end
        wait_idle("idle_after_single");

        // Round robin: both request together after reset, each re-requests once
        do_reset();
        @(posedge clk); #1;
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h31});
        sb.push_back('{ch: 1, rs: 1'b0, d: 8'h32});
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h31});
        sb.push_back('{ch: 1, rs: 1'b0, d: 8'h32});
        fork
            begin
                req_ch(0, 8'h31, 1'b0);
                @(posedge clk); #1;
                req_ch(0, 8'h31, 1'b0);
            end
            begin
                req_ch(1, 8'h32, 1'b0);
                @(posedge clk); #1;
                req_ch(1, 8'h32, 1'b0);
            end
        join
        wait_idle("idle_after_rr");
        chk("rr_sb_drained", 32'(sb.size()), 32'd0);

        // Debug stop request: rs coincident with en
        @(posedge clk); #1;
        sb.push_back('{ch: 1, rs: 1'b1, d: 8'h00});
        req_ch(1, 8'h00, 1'b1);
        wait_idle("idle_after_stop");

        // Reset in cycle 8 of a transfer
        @(posedge clk); #1;
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h55});
        bus.c0_dat = 8'h55;
        bus.c0_req = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_en",   {31'd0, bus.lcd_en}, 32'd0);
        chk("midrst_rs",   {31'd0, bus.lcd_rs}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy},   32'd0);
        chk("midrst_ack",  {30'd0, bus.c0_ack, bus.c1_ack}, 32'd0);
        bus.c0_req = 1'b0;
        sb.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h66});
        req_ch(0, 8'h66, 1'b0);
        wait_idle("idle_after_midrst");

        // Request dropped during SETUP still completes
        @(posedge clk); #1;
        sb.push_back('{ch: 0, rs: 1'b0, d: 8'h77});
        bus.c0_dat = 8'h77;
        bus.c0_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.c0_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus.c0_ack || FIFO;
        end
        chk("drop_ack_seen", {31'd0, got}, 32'd1);
        wait_idle("idle_after_drop");

`ifdef CONFIG_TTY_ARB_FIFO_EN
        // Five back-to-back console bytes through the FIFO
        do_reset();
        for (int i = 0; i < 5; i++) sb.push_back('{ch: 0, rs: 1'b0, d: 8'(8'h10 + i)});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.c0_dat = 8'(8'h10 + i);
            bus.c0_req = 1'b1;
            w = 0;
            got = 1'b0;
            while (!got && w < 300) begin
                @(negedge clk);
                w++;
                got = bus.c0_ack;
            end
            chk($sformatf("fifo_ack_lat_%0d", i), 32'(w), (i < 4) ? 32'd2 : 32'd7);
            @(posedge clk); #1;
            bus.c0_req = 1'b0;
        end
        wait_idle("idle_after_fifo");
`endif

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
